// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control sequencer.
// Covers opcode and ALU encodings, bus_src/ld_en bit positions, the instruction-class
// enum, the sequencer phase enum, and the final T-state of each class.
package cpu_ctrl_pkg;

  // Opcodes, IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // The ALU uses the opcode encoding of its register-form instructions.
  localparam logic [4:0] ALU_ADD = OP_ADD;
  localparam logic [4:0] ALU_SUB = OP_SUB;
  localparam logic [4:0] ALU_AND = OP_AND;
  localparam logic [4:0] ALU_OR  = OP_OR;

  // Bit positions in bus_src, which is {InPort,C,LO,HI,Zlo,MDR,PC}out.
  localparam int BS_W      = 7;
  localparam int BS_PC     = 0;
  localparam int BS_MDR    = 1;
  localparam int BS_ZLO    = 2;
  localparam int BS_HI     = 3;
  localparam int BS_LO     = 4;
  localparam int BS_C      = 5;
  localparam int BS_INPORT = 6;

  // Bit positions in ld_en, which is {OutPort,CON,LO,HI,Z,Y,IR,MDR,PC,MAR}in.
  localparam int LD_W       = 10;
  localparam int LD_MAR     = 0;
  localparam int LD_PC      = 1;
  localparam int LD_MDR     = 2;
  localparam int LD_IR      = 3;
  localparam int LD_Y       = 4;
  localparam int LD_Z       = 5;
  localparam int LD_HI      = 6;
  localparam int LD_LO      = 7;
  localparam int LD_CON     = 8;
  localparam int LD_OUTPORT = 9;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LD, CLS_LDI, CLS_ST, CLS_BR, CLS_JR,
    CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } instr_class_e;

  typedef enum logic [1:0] {
    PH_IDLE, PH_EXEC, PH_HALT
  } phase_e;

  // Final T-state index of each instruction class. Fetch always occupies T0-T2.
  function automatic logic [2:0] last_t_of(input instr_class_e cls);
    logic [2:0] lt;
    lt = 3'd2;
    unique case (cls)
      CLS_ALU_R, CLS_ALU_I, CLS_LDI:            lt = 3'd5;
      CLS_LD, CLS_ST:                           lt = 3'd7;
      CLS_BR:                                   lt = 3'd6;
      CLS_JAL:                                  lt = 3'd4;
      CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO: lt = 3'd3;
      CLS_NOP, CLS_HALT:                        lt = 3'd2;
      default:                                  lt = 3'd2;
    endcase
    return lt;
  endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Maps an opcode to its instruction class and to that class's final T-state.
// Latency: purely combinational. Backpressure: none.
// Ports: opcode (IR[31:27]) in; cls and last_t out. Undefined opcodes decode as NOP.
module opcode_class_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output instr_class_e   cls,
  output logic [2:0]     last_t
);

  always_comb begin
    cls = CLS_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:      cls = CLS_ALU_I;
      OP_LD:                         cls = CLS_LD;
      OP_LDI:                        cls = CLS_LDI;
      OP_ST:                         cls = CLS_ST;
      OP_BR:                         cls = CLS_BR;
      OP_JR:                         cls = CLS_JR;
      OP_JAL:                        cls = CLS_JAL;
      OP_IN:                         cls = CLS_IN;
      OP_OUT:                        cls = CLS_OUT;
      OP_MFHI:                       cls = CLS_MFHI;
      OP_MFLO:                       cls = CLS_MFLO;
      OP_HALT:                       cls = CLS_HALT;
      default:                       cls = CLS_NOP;
    endcase
  end

  assign last_t = last_t_of(cls);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired CPU control unit. It fetches each instruction, decodes it, and steps it through
// T-states T0..T7. All control strobes are Moore-decoded from the T-state and the IR.
// Latency: one T-state per clock, and a new fetch starts straight after the last T-state.
// Backpressure: none. stop is sampled only at an instruction boundary and parks the unit in HALT.
// Ports: clk, reset (asynchronous, active-high), ir, con_ff and stop in.
//        Out: the GPR select strobes gra/grb/grc/rin/rout/ba_out, bus_src (one-hot), ld_en,
//        inc_pc, mem_read, mem_write, alu_op and run.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW     = 5,
  parameter int TSTATES = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ir,
  input  logic            con_ff,
  input  logic            stop,
  output logic            gra,
  output logic            grb,
  output logic            grc,
  output logic            rin,
  output logic            rout,
  output logic            ba_out,
  output logic [BS_W-1:0] bus_src,
  output logic [LD_W-1:0] ld_en,
  output logic            inc_pc,
  output logic            mem_read,
  output logic            mem_write,
  output logic [4:0]      alu_op,
  output logic            run
);

  localparam int TW = $clog2(TSTATES);

  phase_e          phase_q, phase_d;
  logic [TW-1:0]   t_q, t_d;
  instr_class_e    cls;
  logic [2:0]      last_t;
  logic [OPW-1:0]  opcode;

  // The register fields of the IR are consumed by the select/encode stage, not here.
  logic unused_ir_fields;
  assign unused_ir_fields = ^ir[31-OPW:0];

  assign opcode = ir[31 -: OPW];

  opcode_class_decode #(.OPW(OPW)) u_decode (
    .opcode (opcode),
    .cls    (cls),
    .last_t (last_t)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      t_q     <= '0;
    end else begin
      phase_q <= phase_d;
      t_q     <= t_d;
    end
  end

  // Next-state logic. The boundary test uses >= so that an IR that changes under a running
  // instruction cannot make the sequencer overrun into T-states that class never uses.
  // nop/halt finish at T2 on the opcode presented during T2.
  always_comb begin
    phase_d = phase_q;
    t_d     = t_q;
    case (phase_q)
      PH_IDLE: begin
        phase_d = PH_EXEC;
        t_d     = '0;
      end
      PH_EXEC: begin
        if (t_q >= TW'(last_t)) begin
          t_d     = '0;
          phase_d = (cls == CLS_HALT || stop) ? PH_HALT : PH_EXEC;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      PH_HALT: begin
        phase_d = PH_HALT;
        t_d     = '0;
      end
      default: begin
        phase_d = PH_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Output decode
  always_comb begin
    gra       = 1'b0;
    grb       = 1'b0;
    grc       = 1'b0;
    rin       = 1'b0;
    rout      = 1'b0;
    ba_out    = 1'b0;
    bus_src   = '0;
    ld_en     = '0;
    inc_pc    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_op    = 5'b00000;
    run       = 1'b0;

    case (phase_q)
      PH_IDLE: run = 1'b1;
      PH_EXEC: begin
        run    = 1'b1;
        alu_op = ALU_ADD;
        case (t_q)
          3'd0: begin
            bus_src[BS_PC] = 1'b1;
            ld_en[LD_MAR]  = 1'b1;
            ld_en[LD_Z]    = 1'b1;
            inc_pc         = 1'b1;
          end
          3'd1: begin
            bus_src[BS_ZLO] = 1'b1;
            ld_en[LD_PC]    = 1'b1;
            ld_en[LD_MDR]   = 1'b1;
            mem_read        = 1'b1;
          end
          3'd2: begin
            bus_src[BS_MDR] = 1'b1;
            ld_en[LD_IR]    = 1'b1;
          end
          default: begin
            case (cls)
              CLS_ALU_R, CLS_ALU_I: begin
                case (t_q)
                  3'd3: begin
                    grb         = 1'b1;
                    rout        = 1'b1;
                    ld_en[LD_Y] = 1'b1;
                  end
                  3'd4: begin
                    ld_en[LD_Z] = 1'b1;
                    if (cls == CLS_ALU_R) begin
                      grc    = 1'b1;
                      rout   = 1'b1;
                      alu_op = opcode[4:0];
                    end else begin
                      bus_src[BS_C] = 1'b1;
                      if (opcode[4:0] == OP_ANDI)     alu_op = ALU_AND;
                      else if (opcode[4:0] == OP_ORI) alu_op = ALU_OR;
                      else                            alu_op = ALU_ADD;
                    end
                  end
                  3'd5: begin
                    bus_src[BS_ZLO] = 1'b1;
                    gra             = 1'b1;
                    rin             = 1'b1;
                  end
                  default: ;
                endcase
              end
              // ld, ldi and st share the same effective-address sequence, using base + C with
              // R0 read as zero.
              CLS_LD, CLS_LDI, CLS_ST: begin
                case (t_q)
                  3'd3: begin
                    grb         = 1'b1;
                    ba_out      = 1'b1;
                    ld_en[LD_Y] = 1'b1;
                  end
                  3'd4: begin
                    bus_src[BS_C] = 1'b1;
                    ld_en[LD_Z]   = 1'b1;
                  end
                  3'd5: begin
                    bus_src[BS_ZLO] = 1'b1;
                    if (cls == CLS_LDI) begin
                      gra = 1'b1;
                      rin = 1'b1;
                    end else begin
                      ld_en[LD_MAR] = 1'b1;
                    end
                  end
                  3'd6: begin
                    ld_en[LD_MDR] = 1'b1;
                    if (cls == CLS_LD) begin
                      mem_read = 1'b1;
                    end else begin
                      gra  = 1'b1;
                      rout = 1'b1;
                    end
                  end
                  3'd7: begin
                    if (cls == CLS_LD) begin
                      bus_src[BS_MDR] = 1'b1;
                      gra             = 1'b1;
                      rin             = 1'b1;
                    end else begin
                      mem_write = 1'b1;
                    end
                  end
                  default: ;
                endcase
              end
              CLS_BR: begin
                case (t_q)
                  3'd3: begin
                    gra           = 1'b1;
                    rout          = 1'b1;
                    ld_en[LD_CON] = 1'b1;
                  end
                  3'd4: begin
                    bus_src[BS_PC] = 1'b1;
                    ld_en[LD_Y]    = 1'b1;
                  end
                  3'd5: begin
                    bus_src[BS_C] = 1'b1;
                    ld_en[LD_Z]   = 1'b1;
                  end
                  3'd6: begin
                    bus_src[BS_ZLO] = 1'b1;
                    ld_en[LD_PC]    = con_ff;
                  end
                  default: ;
                endcase
              end
              CLS_JR: begin
                gra          = 1'b1;
                rout         = 1'b1;
                ld_en[LD_PC] = 1'b1;
              end
              CLS_JAL: begin
                // The link register is written first, so PC is captured before it is replaced.
                if (t_q == 3'd3) begin
                  bus_src[BS_PC] = 1'b1;
                  grb            = 1'b1;
                  rin            = 1'b1;
                end else begin
                  gra          = 1'b1;
                  rout         = 1'b1;
                  ld_en[LD_PC] = 1'b1;
                end
              end
              CLS_IN: begin
                bus_src[BS_INPORT] = 1'b1;
                gra                = 1'b1;
                rin                = 1'b1;
              end
              CLS_OUT: begin
                gra               = 1'b1;
                rout              = 1'b1;
                ld_en[LD_OUTPORT] = 1'b1;
              end
              CLS_MFHI, CLS_MFLO: begin
                bus_src[(cls == CLS_MFHI) ? BS_HI : BS_LO] = 1'b1;
                gra = 1'b1;
                rin = 1'b1;
              end
              default: ;
            endcase
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule
